// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet geometry, dg source FSM states, dual-rail encoder.
package noc_pkg;

   localparam int PKT_W    = 11;
   localparam int ADDR_W   = 4;
   localparam int DEST_LSB = 7;
   localparam int SRC_LSB  = 3;
   localparam int SEQ_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_VALID,
      ST_NEUTRAL,
      ST_GAP_WAIT,
      ST_DONE
   } dg_state_t;

   typedef struct packed {
      logic [PKT_W-1:0] rail1;
      logic [PKT_W-1:0] rail0;
   } dr_t;

   // Each data bit drives exactly one of its two rails high.
   function automatic dr_t encode_dr(input logic [PKT_W-1:0] d);
      dr_t r;
      r.rail1 = d;
      r.rail0 = ~d;
      return r;
   endfunction

   // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/dg_sync_source_sync2.sv
// Two-flop synchronizer bringing the node's asynchronous enable into CLK.
// Latency 2 cycles; no backpressure.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= d;
         r_q    <= r_meta;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/dg_sync_source.sv
// Clocked e1of2 packet source for one router dg channel; rails change 3 cycles after an e_in edge.
// Waits on the synchronized enable for every phase; start is ignored while a run is busy.
module dg_sync_source
   import noc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] MY_IP     = 4'b0000,
   parameter int                NUM_PKTS  = 16,
   parameter int                GAP       = 4,
   parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   input  logic              dest_mode,
   input  logic [ADDR_W-1:0] fixed_dest,
   output logic [PKT_W-1:0]  d_rail0,
   output logic [PKT_W-1:0]  d_rail1,
   input  logic              e_in,
   output logic              busy,
   output logic              done,
   output logic [15:0]       sent_count
);

   localparam logic [15:0] NUM_PKTS_C = 16'(NUM_PKTS);
   localparam logic [15:0] GAP_M1     = 16'((GAP > 0) ? (GAP - 1) : 0);

   dg_state_t         r_state;
   logic [7:0]        r_lfsr;
   logic              r_mode;
   logic [ADDR_W-1:0] r_fixed;
   logic [15:0]       r_gap_cnt;
   logic [15:0]       r_sent;
   logic              r_busy;
   logic              r_done;
   logic [PKT_W-1:0]  r_rail0;
   logic [PKT_W-1:0]  r_rail1;

   logic              w_e_s;
   logic [7:0]        w_lfsr_nxt;
   logic [ADDR_W-1:0] w_cand;
   logic [ADDR_W-1:0] w_dest;
   logic [PKT_W-1:0]  w_pkt;
   dr_t               w_code;

   sync2 u_sync_e (
      .clk (CLK),
      .rst (RESET),
      .d   (e_in),
      .q   (w_e_s)
   );

   // A node never addresses itself, so a self-hit is nudged to the neighbouring IP.
   assign w_lfsr_nxt = lfsr_step(r_lfsr);
   assign w_cand     = r_mode ? r_fixed : w_lfsr_nxt[ADDR_W-1:0];
   assign w_dest     = (w_cand == MY_IP) ? (w_cand ^ 4'b0001) : w_cand;
   assign w_pkt      = {w_dest, MY_IP, r_sent[2:0]};
   assign w_code     = encode_dr(w_pkt);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_lfsr    <= LFSR_SEED;
         r_mode    <= 1'b0;
         r_fixed   <= '0;
         r_gap_cnt <= '0;
         r_sent    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rail0   <= '0;
         r_rail1   <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_sent  <= '0;
                  r_done  <= 1'b0;
                  r_mode  <= dest_mode;
                  r_fixed <= fixed_dest;
                  r_busy  <= 1'b1;
                  r_state <= ST_WAIT_RDY;
               end
            end
            ST_WAIT_RDY: begin
               if (w_e_s) begin
                  r_lfsr  <= w_lfsr_nxt;
                  r_rail1 <= w_code.rail1;
                  r_rail0 <= w_code.rail0;
                  r_state <= ST_VALID;
               end
            end
            ST_VALID: begin
               if (!w_e_s) begin
                  r_rail1 <= '0;
                  r_rail0 <= '0;
                  r_sent  <= r_sent + 16'd1;
                  r_state <= ST_NEUTRAL;
               end
            end
            ST_NEUTRAL: begin
               if (w_e_s) begin
                  if (r_sent == NUM_PKTS_C) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_DONE;
                  end else if (GAP > 0) begin
                     r_gap_cnt <= GAP_M1;
                     r_state   <= ST_GAP_WAIT;
                  end else begin
                     r_state <= ST_WAIT_RDY;
                  end
               end
            end
            ST_GAP_WAIT: begin
               if (r_gap_cnt == 16'd0) begin
                  r_state <= ST_WAIT_RDY;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 16'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign d_rail0    = r_rail0;
   assign d_rail1    = r_rail1;
   assign busy       = r_busy;
   assign done       = r_done;
   assign sent_count = r_sent;

endmodule
